rcv_sequencer: RTL and testbench

Receive control unit for the serial command/data link. It detects and qualifies start bits and sequences the bit/packet timer (10 clk/bit, 9 strobes/packet = 8 data + stop). It checks the stop bit, issues the buffer load, and tracks the data-ready, framing-error and overrun status. It sits between the edge detector, the timer, the 9-bit shift register and the rx data buffer.

---
 rtl/rcv_pkg.sv | 18 +
 rtl/rcv_sequencer_if.sv | 46 ++++
 rtl/rcv_sequencer.sv | 118 +++++++++++
 tb/tb_rcv_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// rcv_pkg: shared types and constants for the serial receive path.
//   rcv_state_t      : receive sequencer state (3-bit encoding)
//   CLKS_PER_BIT     : clocks per serial bit, used by the bit/packet timer
//   BITS_PER_PACKET  : shift strobes per packet (8 data + stop)
package rcv_pkg;

    localparam int CLKS_PER_BIT    = 10;
    localparam int BITS_PER_PACKET = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECEIVE   = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4
    } rcv_state_t;

endpackage

// File: rtl/rcv_sequencer_if.sv
// rcv_sequencer_if: bundle between the receive sequencer and its neighbours
// (edge detector, bit/packet timer, shift register, rx buffer, consumer).
//   serial_in          : synchronized serial line, idle high
//   start_bit_detected : one-cycle falling-edge pulse
//   packet_done        : timer flag, 9th shift strobe reached
//   stop_bit           : stop bit from the shift register
//   data_read          : one-cycle pulse, consumer took rx_data
//   enable_timer, load_buffer, rx_busy        : control outputs
//   data_ready, framing_error, overrun_error  : status flags
//   state_dbg          : current sequencer state for observation
//
// Handshake: there is no valid/ready pair on this link. Every request input
// (start_bit_detected, packet_done, data_read) is a single-cycle pulse that
// is acted on at the rising clk edge that samples it; load_buffer is a
// single-cycle pulse the buffer must take on that same edge, with no stall.
interface rcv_sequencer_if;
    import rcv_pkg::*;

    logic       serial_in;
    logic       start_bit_detected;
    logic       packet_done;
    logic       stop_bit;
    logic       data_read;
    logic       enable_timer;
    logic       load_buffer;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       rx_busy;
    rcv_state_t state_dbg;

    // master: the surrounding link logic driving the sequencer
    modport master (
        output serial_in, start_bit_detected, packet_done, stop_bit, data_read,
        input  enable_timer, load_buffer, data_ready, framing_error,
               overrun_error, rx_busy, state_dbg
    );

    // slave: the sequencer itself
    modport slave (
        input  serial_in, start_bit_detected, packet_done, stop_bit, data_read,
        output enable_timer, load_buffer, data_ready, framing_error,
               overrun_error, rx_busy, state_dbg
    );

endinterface

// File: rtl/rcv_sequencer.sv
// rcv_sequencer: receive control unit for the serial command/data link.
// Qualifies a start edge by re-sampling the line half a bit later, runs the
// bit/packet timer for a full packet, checks the stop bit, pulses the buffer
// load and keeps the data-ready / framing / overrun status.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : rcv_sequencer_if.slave (see interface header for signals)
// Parameters:
//   HALF_BIT_CLKS : clocks after the start pulse before re-sampling serial_in
//   CNT_BITS      : width of the half-bit counter
module rcv_sequencer
    import rcv_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 5,
    parameter int CNT_BITS      = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    rcv_sequencer_if.slave bus
);

    localparam logic [CNT_BITS-1:0] HALF_LAST = CNT_BITS'(HALF_BIT_CLKS - 1);

    rcv_state_t          state, next_state;
    logic [CNT_BITS-1:0] cnt, next_cnt;

    logic enable_q, load_q, busy_q;
    logic next_enable, next_load, next_busy;
    logic ready_q, ferr_q, oerr_q;
    logic next_ready, next_ferr, next_oerr;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_ready = ready_q;
        next_ferr  = ferr_q;
        next_oerr  = oerr_q;

        case (state)
            IDLE: begin
                if (bus.start_bit_detected) begin
                    next_state = START_CHK;
                    next_cnt   = '0;
                end
            end
            START_CHK: begin
                next_cnt = cnt + 1'b1;
                // Line back high half a bit in means the edge was a glitch.
                if (cnt == HALF_LAST) begin
                    next_state = bus.serial_in ? IDLE : RECEIVE;
                end
            end
            RECEIVE: begin
                if (bus.packet_done) begin
                    next_state = STOP_CHK;
                end
            end
            STOP_CHK: begin
                if (bus.stop_bit) begin
                    next_ferr  = 1'b0;
                    next_state = LOAD;
                end else begin
                    next_ferr  = 1'b1;
                    next_state = IDLE;
                end
            end
            LOAD: begin
                // A read in the load cycle consumed the old byte, so the new
                // byte overwrites nothing unread.
                next_ready = 1'b1;
                next_oerr  = ready_q & ~bus.data_read;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (state != LOAD && bus.data_read) begin
            next_ready = 1'b0;
            next_oerr  = 1'b0;
        end

        // Control outputs are registered copies of the next-state decode so
        // they are Moore outputs with no combinational path from inputs.
        next_enable = (next_state == RECEIVE);
        next_load   = (next_state == LOAD);
        next_busy   = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            enable_q <= 1'b0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            enable_q <= next_enable;
            load_q   <= next_load;
            busy_q   <= next_busy;
            ready_q  <= next_ready;
            ferr_q   <= next_ferr;
            oerr_q   <= next_oerr;
        end
    end

    assign bus.enable_timer  = enable_q;
    assign bus.load_buffer   = load_q;
    assign bus.rx_busy       = busy_q;
    assign bus.data_ready    = ready_q;
    assign bus.framing_error = ferr_q;
    assign bus.overrun_error = oerr_q;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_rcv_sequencer.sv
// tb_rcv_sequencer: self-checking bench for rcv_sequencer. A timeline model
// predicts every output each cycle from the start-pulse time and the fixed
// packet length; directed scenarios add literal checks on top.
module tb_rcv_sequencer;
    import rcv_pkg::*;

    localparam int HALF = 5;
    localparam int TOT  = CLKS_PER_BIT * BITS_PER_PACKET;   // 90 enable clocks

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rcv_sequencer_if bus ();

    rcv_sequencer #(.HALF_BIT_CLKS(HALF), .CNT_BITS(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // ---------------- bit/packet timer stand-in ----------------
    int tcnt;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) tcnt <= 0;
        else if (bus.enable_timer && !bus.packet_done) tcnt <= tcnt + 1;
        else tcnt <= 0;
    end
    assign bus.packet_done = bus.enable_timer && (tcnt == TOT - 1);

    // ---------------- counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return {26'd0, bus.rx_busy, bus.enable_timer, bus.load_buffer,
                bus.data_ready, bus.framing_error, bus.overrun_error};
    endfunction

    function automatic int flags();
        return {29'd0, bus.data_ready, bus.framing_error, bus.overrun_error};
    endfunction

    // ---------------- behavioural model ----------------
    // A packet is a timeline measured from the cycle its start pulse is
    // accepted: sample at +HALF, timer runs +HALF+1..+HALF+TOT, stop check
    // at +HALF+TOT+1, load at +HALF+TOT+2.
    int m_cyc = 0;
    bit m_active = 0;
    int m_t0 = 0;
    bit m_dr = 0, m_fe = 0, m_ov = 0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active = 0;
            m_dr = 0; m_fe = 0; m_ov = 0;
        end else begin
            bit was_active;
            bit loaded;
            int k;
            was_active = m_active;
            loaded = 0;
            k = m_cyc - m_t0;
            if (m_active) begin
                if (k == HALF && bus.serial_in) begin
                    m_active = 0;
                end else if (k == HALF + TOT + 1) begin
                    m_fe = !bus.stop_bit;
                    if (!bus.stop_bit) m_active = 0;
                end else if (k == HALF + TOT + 2) begin
                    m_ov = m_dr && !bus.data_read;
                    m_dr = 1;
                    m_active = 0;
                    loaded = 1;
                end
            end
            if (!loaded && bus.data_read) begin
                m_dr = 0;
                m_ov = 0;
            end
            if (!was_active && bus.start_bit_detected) begin
                m_active = 1;
                m_t0 = m_cyc;
            end
            m_cyc++;
        end
    end

    // ---------------- compare process + monitor counts ----------------
    int mon_cyc = 0, en_cnt = 0, ld_cnt = 0, busy_cnt = 0, pd_at = 0, ld_at = 0;

    always @(negedge clk) begin
        int k;
        int exp_v;
        k = m_cyc - m_t0;
        exp_v = {26'd0,
                 m_active,
                 m_active && k >= HALF + 1 && k <= HALF + TOT,
                 m_active && k == HALF + TOT + 2,
                 m_dr, m_fe, m_ov};
        check("outputs{busy,en,ld,dr,fe,ov}", outs(), exp_v);
        mon_cyc++;
        en_cnt   += int'(bus.enable_timer);
        ld_cnt   += int'(bus.load_buffer);
        busy_cnt += int'(bus.rx_busy);
        if (bus.packet_done) pd_at = mon_cyc;
        if (bus.load_buffer) ld_at = mon_cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.rx_busy && n < 200) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", int'(bus.rx_busy), 0);
    endtask

    // Drives one packet starting in the current cycle. spur_i >= 0 adds an
    // extra start pulse at that cycle offset.
    task automatic send_packet(input logic [7:0] b, input logic stop,
                               input bit glitch, input bit rd_load,
                               input bit rnd_rd, input int spur_i);
        int len;
        len = glitch ? 12 : 104;
        bus.stop_bit = stop;
        for (int i = 0; i < len; i++) begin
            bus.start_bit_detected = (i == 0) || (i == spur_i);
            if (glitch)       bus.serial_in = (i >= 2);
            else if (i < 10)  bus.serial_in = 1'b0;
            else if (i < 90)  bus.serial_in = b[(i - 10) / 10];
            else if (i < 100) bus.serial_in = stop;
            else              bus.serial_in = 1'b1;
            bus.data_read = (rd_load && i == HALF + TOT + 2) ||
                            (rnd_rd && $urandom_range(0, 15) == 0);
            tick();
        end
        bus.start_bit_detected = 1'b0;
        bus.data_read = 1'b0;
        bus.serial_in = 1'b1;
        wait_idle();
    endtask

    task automatic read_pulse();
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    int e0, l0, b0;

    initial begin
        bus.serial_in = 1'b1;
        bus.start_bit_detected = 1'b0;
        bus.stop_bit = 1'b1;
        bus.data_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        n_rst = 1'b1;
        repeat (3) tick();

        // valid byte 0xA5
        e0 = en_cnt; l0 = ld_cnt;
        send_packet(8'hA5, 1'b1, 0, 0, 0, -1);
        check("a5_enable_clks", en_cnt - e0, 90);
        check("a5_load_pulses", ld_cnt - l0, 1);
        check("a5_pd_to_load", ld_at - pd_at, 2);
        check("a5_flags{dr,fe,ov}", flags(), 3'b100);
        read_pulse();
        check("read_clears_dr", flags(), 3'b000);

        // glitch: line back high after 2 clk
        e0 = en_cnt; b0 = busy_cnt;
        send_packet(8'h00, 1'b1, 1, 0, 0, -1);
        check("glitch_busy_clks", busy_cnt - b0, HALF);
        check("glitch_enable_clks", en_cnt - e0, 0);
        check("glitch_flags", flags(), 3'b000);

        // bad stop bit, with a spurious start pulse mid-receive
        l0 = ld_cnt;
        send_packet(8'h5A, 1'b0, 0, 0, 0, 50);
        check("stop0_flags", flags(), 3'b010);
        check("stop0_no_load", ld_cnt - l0, 0);
        send_packet(8'h11, 1'b1, 0, 0, 0, -1);
        check("good_clears_fe", flags(), 3'b100);

        // second byte unread -> overrun
        send_packet(8'h22, 1'b1, 0, 0, 0, -1);
        check("overrun_flags", flags(), 3'b101);
        read_pulse();
        check("read_clears_ov", flags(), 3'b000);

        // read coincident with load
        send_packet(8'h33, 1'b1, 0, 0, 0, -1);
        send_packet(8'h44, 1'b1, 0, 1, 0, -1);
        check("read_at_load_flags", flags(), 3'b100);

        // reset 40 clk into RECEIVE
        bus.start_bit_detected = 1'b1;
        bus.serial_in = 1'b0;
        tick();
        bus.start_bit_detected = 1'b0;
        for (int i = 1; i < HALF + 1 + 40; i++) tick();
        check("midrst_pre_enable", int'(bus.enable_timer), 1);
        n_rst = 1'b0;
        #1;
        check("midrst_outputs", outs(), 0);
        tick();
        n_rst = 1'b1;
        bus.serial_in = 1'b1;
        repeat (2) tick();
        l0 = ld_cnt;
        send_packet(8'h3C, 1'b1, 0, 0, 0, -1);
        check("post_rst_load", ld_cnt - l0, 1);
        check("post_rst_flags", flags(), 3'b100);

        // randomized packets
        for (int p = 0; p < 30; p++) begin
            int gap;
            send_packet(8'($urandom_range(0, 255)),
                        ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 5) == 0),
                        1,
                        ($urandom_range(0, 1) ? int'($urandom_range(10, 95)) : -1));
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                bus.data_read = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.data_read = 1'b0;
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
